// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan controller: FSM states, channel count, default settle time.
package mux_scan_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned NCH        = 4;
  localparam int unsigned SETTLE_DEF = 1;
  localparam logic [1:0]  LAST_CH    = 2'(NCH - 1);

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Control/data bundle between the scan controller (master) and the mux/consumer side (slave).
interface mux_scan_ctrl_if;
  import mux_scan_defs::*;

  logic           start;
  logic           cont;
  logic           mux_in;
  logic           ready;
  logic           s1;
  logic           s0;
  logic [NCH-1:0] data;
  logic           valid;
  logic           busy;

  modport master (
    input  start, cont, mux_in, ready,
    output s1, s0, data, valid, busy
  );

  modport slave (
    output start, cont, mux_in, ready,
    input  s1, s0, data, valid, busy
  );

endinterface

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Loadable down-counter that times the select-settle interval; zero flag marks expiry.
module settle_timer #(
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [SW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [SW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a 4-to-1 mux channel by channel, lets each select settle, then presents the 4-bit frame.
module mux_scan_ctrl
  import mux_scan_defs::*;
#(
  parameter int SETTLE = SETTLE_DEF,
  parameter int SW     = 4
) (
  input  logic            clk,
  input  logic            rst,
  mux_scan_ctrl_if.master bus
);

  state_t         state, state_nxt;
  logic [1:0]     ch, ch_nxt;
  logic [1:0]     sel_q, sel_nxt;
  logic [NCH-1:0] shadow, shadow_nxt;
  logic [NCH-1:0] data_q, data_nxt;
  logic           valid_q, valid_nxt;
  logic           busy_q, busy_nxt;
  logic           t_load, t_en, t_zero;

  settle_timer #(.SW(SW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (SW'(SETTLE - 1)),
    .en       (t_en),
    .zero     (t_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch      <= '0;
      sel_q   <= '0;
      shadow  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      sel_q   <= sel_nxt;
      shadow  <= shadow_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      busy_q  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ch_nxt     = ch;
    sel_nxt    = sel_q;
    shadow_nxt = shadow;
    data_nxt   = data_q;
    valid_nxt  = valid_q;
    t_load     = 1'b0;
    t_en       = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SETUP;
          ch_nxt    = '0;
          sel_nxt   = '0;
          t_load    = 1'b1;
        end
      end
      SETUP: begin
        if (t_zero) state_nxt = SAMPLE;
        else        t_en      = 1'b1;
      end
      SAMPLE: begin
        // The select only moves on SETUP entry, so mux_in here always belongs to ch.
        shadow_nxt[ch] = bus.mux_in;
        if (ch == LAST_CH) begin
          state_nxt = DONE;
          data_nxt  = shadow_nxt;
          valid_nxt = 1'b1;
        end else begin
          state_nxt = SETUP;
          ch_nxt    = ch + 2'd1;
          sel_nxt   = ch + 2'd1;
          t_load    = 1'b1;
        end
      end
      DONE: begin
        if (bus.ready) begin
          valid_nxt = 1'b0;
          if (bus.cont) begin
            state_nxt = SETUP;
            ch_nxt    = '0;
            sel_nxt   = '0;
            t_load    = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.s1    = sel_q[1];
  assign bus.s0    = sel_q[0];
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: SETTLE=1 and SETTLE=3 instances driving a modelled 4-to-1 mux.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] da, db;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  mux_scan_ctrl_if ba ();
  mux_scan_ctrl_if bb ();

  assign ba.mux_in = da[{ba.s1, ba.s0}];
  assign bb.mux_in = db[{bb.s1, bb.s0}];

  mux_scan_ctrl #(.SETTLE(1), .SW(4)) dut_a (.clk(clk), .rst(rst), .bus(ba));
  mux_scan_ctrl #(.SETTLE(3), .SW(4)) dut_b (.clk(clk), .rst(rst), .bus(bb));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic obs(input bit use_b, output logic [1:0] s, output logic v,
                     output logic b, output logic [3:0] d);
    if (use_b) begin
      s = {bb.s1, bb.s0}; v = bb.valid; b = bb.busy; d = bb.data;
    end else begin
      s = {ba.s1, ba.s0}; v = ba.valid; b = ba.busy; d = ba.data;
    end
  endtask

  // Call right after the frame-starting edge. poke!=0 pulses start on dut_a at that edge.
  task automatic run_frame(input bit use_b, input int unsigned per, input logic [3:0] exp,
                           input int unsigned poke, input string tag);
    logic [1:0]  s;
    logic        v, b;
    logic [3:0]  d, d0;
    int unsigned last;
    last = 4 * per;
    obs(use_b, s, v, b, d0);
    chk({tag, ":sel0"}, 32'(s), 0);
    chk({tag, ":busy0"}, 32'(b), 1);
    chk({tag, ":valid0"}, 32'(v), 0);
    for (int unsigned k = 1; k <= last; k++) begin
      if (!use_b) ba.start = (poke != 0) && (k == poke);
      tick();
      obs(use_b, s, v, b, d);
      chk($sformatf("%s:sel@%0d", tag, k), 32'(s), (k >= last) ? 3 : k / per);
      chk($sformatf("%s:valid@%0d", tag, k), 32'(v), (k == last) ? 1 : 0);
      chk($sformatf("%s:busy@%0d", tag, k), 32'(b), 1);
      if (k < last) chk($sformatf("%s:hold@%0d", tag, k), 32'(d), 32'(d0));
    end
    if (!use_b) ba.start = 1'b0;
    chk({tag, ":data"}, 32'(d), 32'(exp));
  endtask

  task automatic start_a();
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, ":sel"}, 32'({ba.s1, ba.s0}), 0);
    chk({tag, ":data"}, 32'(ba.data), 0);
    chk({tag, ":valid"}, 32'(ba.valid), 0);
    chk({tag, ":busy"}, 32'(ba.busy), 0);
  endtask

  initial begin
    rst = 1'b1;
    ba.start = 1'b0; ba.cont = 1'b0; ba.ready = 1'b0;
    bb.start = 1'b0; bb.cont = 1'b0; bb.ready = 1'b0;
    da = 4'b0000; db = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    chk_zero_a("rst");
    chk("rst_b:valid", 32'(bb.valid), 0);
    chk("rst_b:busy", 32'(bb.busy), 0);

    // Basic frame, SETTLE=1
    da = 4'b1010;
    start_a();
    run_frame(1'b0, 2, 4'b1010, 0, "f1010");

    // Consumer stall then accept with cont=0
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall:valid@%0d", i), 32'(ba.valid), 1);
      chk($sformatf("stall:data@%0d", i), 32'(ba.data), 32'(4'b1010));
      chk($sformatf("stall:sel@%0d", i), 32'({ba.s1, ba.s0}), 3);
    end
    ba.ready = 1'b1;
    tick();
    ba.ready = 1'b0;
    chk("accept:valid", 32'(ba.valid), 0);
    chk("accept:busy", 32'(ba.busy), 0);
    chk("accept:data", 32'(ba.data), 32'(4'b1010));

    // SETTLE=3 instance
    db = 4'b0110;
    bb.start = 1'b1;
    tick();
    bb.start = 1'b0;
    run_frame(1'b1, 4, 4'b0110, 0, "s3");

    // start while busy is ignored
    da = 4'b1100;
    start_a();
    run_frame(1'b0, 2, 4'b1100, 3, "stray");
    // start and ready together in DONE: ready wins, back to IDLE
    ba.start = 1'b1; ba.ready = 1'b1;
    tick();
    ba.start = 1'b0; ba.ready = 1'b0;
    chk("sr:valid", 32'(ba.valid), 0);
    chk("sr:busy", 32'(ba.busy), 0);
    tick();
    chk("sr:idle", 32'(ba.busy), 0);

    // Continuous mode: second frame without start
    da = 4'b1111;
    ba.cont = 1'b1;
    start_a();
    run_frame(1'b0, 2, 4'b1111, 0, "c1");
    da = 4'b0001;
    ba.ready = 1'b1;
    tick();
    ba.ready = 1'b0;
    ba.cont = 1'b0;
    chk("c:valid", 32'(ba.valid), 0);
    run_frame(1'b0, 2, 4'b0001, 0, "c2");
    ba.ready = 1'b1;
    tick();
    ba.ready = 1'b0;
    chk("c2acc:busy", 32'(ba.busy), 0);

    // Reset during channel-2 SETUP discards the frame
    da = 4'b1010;
    start_a();
    for (int i = 0; i < 4; i++) tick();
    chk("mid:sel", 32'({ba.s1, ba.s0}), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero_a("midrst");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("norestart:valid@%0d", i), 32'(ba.valid), 0);
    end
    chk("norestart:busy", 32'(ba.busy), 0);
    da = 4'b0011;
    start_a();
    run_frame(1'b0, 2, 4'b0011, 0, "clean");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
